// File: rtl/fsk_tx_scheduler.sv
// fsk_tx_scheduler: round-robin arbiter that shares one FSK modulator between
// two requesters. A granted codeword is held on Hamcode for one full frame of
// CODE_BITS x BIT_CYCLES clocks. A silent gap follows each frame. The modulator
// is kept in reset whenever no frame is on air.
module fsk_tx_scheduler #(
  parameter int CODE_BITS  = 14,
  parameter int BIT_CYCLES = 16,
  parameter int GAP_CYCLES = 16,
  parameter logic [CODE_BITS-1:0] IDLE_WORD = {CODE_BITS{1'b0}}
) (
  input  logic                 FSK_clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [CODE_BITS-1:0] req0_code,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [CODE_BITS-1:0] req1_code,
  output logic                 req1_ready,
  output logic [CODE_BITS-1:0] Hamcode,
  output logic                 mod_rst,
  output logic                 grant_id,
  output logic                 busy,
  output logic [3:0]           bit_idx,
  output logic                 frame_start,
  output logic                 frame_done
);

  localparam int FRAME_LEN = CODE_BITS * BIT_CYCLES;
  localparam int FW        = $clog2(FRAME_LEN);
  localparam int GW        = (GAP_CYCLES > 32'sd1) ? $clog2(GAP_CYCLES) : 32'sd1;

  localparam logic [FW-1:0] FRAME_ZERO = {FW{1'b0}};
  localparam logic [FW-1:0] FRAME_ONE  = FW'(32'sd1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 32'sd1);
  localparam logic [FW-1:0] BIT_DIV    = FW'(BIT_CYCLES);
  localparam logic [GW-1:0] GAP_ZERO   = {GW{1'b0}};
  localparam logic [GW-1:0] GAP_ONE    = GW'(32'sd1);
  localparam logic [GW-1:0] GAP_LAST   =
    GW'((GAP_CYCLES > 32'sd0) ? (GAP_CYCLES - 32'sd1) : 32'sd0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]           state;
  logic [1:0]           state_nx;
  logic [FW-1:0]        frame_cnt;
  logic [FW-1:0]        frame_cnt_nx;
  logic [GW-1:0]        gap_cnt;
  logic [GW-1:0]        gap_cnt_nx;
  logic                 last_grant;
  logic                 last_grant_nx;
  logic                 grant_id_nx;
  logic [CODE_BITS-1:0] hamcode_nx;
  logic [3:0]           bit_idx_nx;
  logic                 granted_valid;
  logic [CODE_BITS-1:0] granted_code;

  // Only the granted requester is offered an accept pulse, and only in GRANT
  assign req0_ready = (state == ST_GRANT) && (grant_id == 1'b0) && req0_valid;
  assign req1_ready = (state == ST_GRANT) && (grant_id == 1'b1) && req1_valid;

  // Select the valid and codeword of whichever requester holds the grant
  always_comb begin
    granted_valid = req0_valid;
    granted_code  = req0_code;
    if (grant_id) begin
      granted_valid = req1_valid;
      granted_code  = req1_code;
    end else begin
      granted_valid = req0_valid;
      granted_code  = req0_code;
    end
  end

  // Next-state, counter and held-data decode for the four-phase schedule
  always_comb begin
    state_nx      = state;
    frame_cnt_nx  = frame_cnt;
    gap_cnt_nx    = gap_cnt;
    last_grant_nx = last_grant;
    grant_id_nx   = grant_id;
    hamcode_nx    = Hamcode;
    case (state)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          state_nx = ST_GRANT;
          if (req0_valid && req1_valid) begin
            grant_id_nx = ~last_grant;
          end else begin
            grant_id_nx = req1_valid;
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (granted_valid) begin
          state_nx      = ST_SEND;
          hamcode_nx    = granted_code;
          last_grant_nx = grant_id;
          frame_cnt_nx  = FRAME_ZERO;
        end else begin
          // Requester withdrew: fall back without touching fairness history
          state_nx = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt_nx = FRAME_ZERO;
          gap_cnt_nx   = GAP_ZERO;
          if (GAP_CYCLES == 32'sd0) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_GAP;
          end
        end else begin
          frame_cnt_nx = frame_cnt + FRAME_ONE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_nx = GAP_ZERO;
          state_nx   = ST_IDLE;
        end else begin
          gap_cnt_nx = gap_cnt + GAP_ONE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Bit index of the upcoming cycle so the registered copy lines up with SEND
  always_comb begin
    bit_idx_nx = 4'd0;
    if (state_nx == ST_SEND) begin
      bit_idx_nx = 4'(frame_cnt_nx / BIT_DIV);
    end else begin
      bit_idx_nx = 4'd0;
    end
  end

  // Register state, counters and all outputs; reset abandons any frame in flight
  always_ff @(posedge FSK_clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      frame_cnt   <= FRAME_ZERO;
      gap_cnt     <= GAP_ZERO;
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      Hamcode     <= IDLE_WORD;
      mod_rst     <= 1'b1;
      busy        <= 1'b0;
      bit_idx     <= 4'd0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_nx;
      frame_cnt   <= frame_cnt_nx;
      gap_cnt     <= gap_cnt_nx;
      last_grant  <= last_grant_nx;
      grant_id    <= grant_id_nx;
      Hamcode     <= hamcode_nx;
      mod_rst     <= (state_nx != ST_SEND);
      busy        <= (state_nx != ST_IDLE);
      bit_idx     <= bit_idx_nx;
      frame_start <= (state_nx == ST_SEND) && (frame_cnt_nx == FRAME_ZERO);
      frame_done  <= (state_nx == ST_SEND) && (frame_cnt_nx == FRAME_LAST);
    end
  end

endmodule
